ex_div_unit: RTL and testbench

- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions, located in the EX stage.
- Consumes the forwarded operands produced by the EX forwarding select (rs1_in_o/rs2_in_o) and returns one 32-bit result.
- Holds busy_o high while computing; the hazard/stall logic uses it to freeze IF/ID/EX.
- Results are written back through the normal EX result path when done_o pulses.

---
 rtl/ex_div_unit_pkg.sv | 21 ++
 rtl/ex_div_unit_step.sv | 23 ++
 rtl/ex_div_unit.sv | 146 ++++++++++++++
 tb/tb_ex_div_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ex_div_unit_pkg.sv
// rtl/ex_div_unit_pkg.sv - shared types and constants for the EX-stage divider
package ex_div_unit_pkg;

  localparam int DIV_XLEN = 32;
  localparam int DIV_ITER = DIV_XLEN;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_t;

endpackage

// File: rtl/ex_div_unit_step.sv
// rtl/ex_div_unit_step.sv - one restoring-division bit: shift {rem,quo} and trial-subtract
module ex_div_unit_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          ge;

  // rem < divisor is invariant, so the 33-bit signed difference never overflows
  assign rem_sh = {rem_i, quo_i[XLEN-1]};
  assign diff   = rem_sh - {1'b0, divisor_i};
  assign ge     = ~diff[XLEN];
  assign rem_o  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_o  = {quo_i[XLEN-2:0], ge};

endmodule

// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU), EX stage
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int XLEN = DIV_XLEN,
  parameter int ITER = DIV_ITER
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  div_op_t         op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state_q, state_d;
  div_op_t          op_q, op_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic [XLEN-1:0]  step_rem, step_quo;
  logic [XLEN-1:0]  abs1, abs2, fix_val;
  logic             in_signed, in_is_div, div_zero, ovf;

  ex_div_unit_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Op encoding: bit0 set = unsigned, bit1 set = remainder
  assign in_signed = ~op_i[0];
  assign in_is_div = ~op_i[1];
  assign abs1      = rs1_i[XLEN-1] ? (~rs1_i + 1'b1) : rs1_i;
  assign abs2      = rs2_i[XLEN-1] ? (~rs2_i + 1'b1) : rs2_i;
  assign div_zero  = (rs2_i == '0);
  assign ovf       = in_signed && (rs1_i == INT_MIN) && (rs2_i == '1);

  always_comb begin
    fix_val = '0;
    unique case (op_q)
      OP_DIV:  fix_val = sq_q ? (~quo_q + 1'b1) : quo_q;
      OP_DIVU: fix_val = quo_q;
      OP_REM:  fix_val = sr_q ? (~rem_q + 1'b1) : rem_q;
      OP_REMU: fix_val = rem_q;
      default: fix_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    sq_d     = sq_q;
    sr_d     = sr_q;
    result_d = result_q;
    // Flush freezes all datapath state so result_o keeps its last value
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_d  = op_i;
            rem_d = '0;
            cnt_d = CNT_W'(ITER - 1);
            quo_d = in_signed ? abs1 : rs1_i;
            dvs_d = in_signed ? abs2 : rs2_i;
            sq_d  = in_signed & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
            sr_d  = in_signed & rs1_i[XLEN-1];
            if (div_zero) begin
              result_d = in_is_div ? '1 : rs1_i;
              state_d  = S_DONE;
            end else if (ovf) begin
              result_d = in_is_div ? INT_MIN : '0;
              state_d  = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_FIX: begin
          result_d = fix_val;
          state_d  = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= OP_DIV;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      sq_q     <= 1'b0;
      sr_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      sq_q     <= sq_d;
      sr_q     <= sr_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - scoreboard bench for ex_div_unit
module tb_ex_div_unit;
  import ex_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  div_op_t     op = OP_DIV;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ex_div_unit dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .op_i     (op),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .flush_i  (flush),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result=%h want no done", result);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input div_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit poke);
    int cycles;
    int busy_cnt;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cycles < 60) begin
      if (busy === 1'b1) busy_cnt++;
      if (poke && cycles == 5) begin
        start = 1'b1; op = OP_REMU; rs1 = 32'd3; rs2 = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    if (cycles >= 60) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      check("done_timeout", 32'(cycles), 32'(lat));
    end else begin
      check("latency", 32'(cycles), 32'(lat));
      check("busy_cycles", 32'(busy_cnt), 32'(lat));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [31:0] held;

  initial begin
    idle_cycles(3);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;

    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    do_op(OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    do_op(OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1'b0);
    do_op(OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1'b0);
    do_op(OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 33, 1'b0);
    do_op(OP_REM,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 33, 1'b0);
    do_op(OP_DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 1'b0);
    do_op(OP_DIV,  32'h80000000, 32'd3, 32'hD5555556, 33, 1'b0);
    do_op(OP_REM,  32'h80000000, 32'd3, 32'hFFFFFFFE, 33, 1'b0);
    do_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 1'b0);
    do_op(OP_REMU, 32'd5, 32'd0, 32'd5, 0, 1'b0);
    do_op(OP_DIV,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 0, 1'b0);
    do_op(OP_REM,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 0, 1'b0);
    do_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1'b0);
    do_op(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 1'b0);

    // Flush mid-CALC: nothing pushed, so any done_o is flagged by the monitor
    held = result;
    @(negedge clk);
    op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result", result, held);
    idle_cycles(2);
    // Flush and start together: no operation may launch
    start = 1'b1; flush = 1'b1; op = OP_DIVU; rs1 = 32'd8; rs2 = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'b0, busy}, 32'd0);
    check("flush_start_result", result, held);
    idle_cycles(40);
    do_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    op = OP_DIV; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(10);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_done", {31'b0, done}, 32'd0);
    check("async_rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(OP_DIV, 32'd20, 32'd4, 32'd5, 33, 1'b0);

    // Back-to-back, then a start pulse (with new operands) during CALC
    do_op(OP_REMU, 32'd17, 32'd5, 32'd2, 33, 1'b0);
    do_op(OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, 1'b0);
    do_op(OP_DIVU, 32'd1000, 32'd3, 32'd333, 33, 1'b1);

    idle_cycles(5);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
